param_delay_line: RTL

- Parametrised multi-channel pipeline delay line with stall enable and per-slot valid tracking.
- Holds DEPTH stages of CHANNELS x BITNESS data; each enabled cycle shifts by one stage.
- Used in the iterative FFT datapath to align butterfly operands and twiddle products across pipeline stages. Typical use: CHANNELS=2 for re/im.
- Reports how many valid words are in flight, so control can drain or wait.

---
 rtl/param_delay_line_if.sv | 28 ++
 rtl/param_delay_line.sv | 60 ++++++
 2 files changed

// File: rtl/param_delay_line_if.sv
// Handshake bundle for param_delay_line: shift enable, input word/valid and
// registered output word/valid plus occupancy flags.
interface param_delay_line_if #(
  parameter int BITNESS  = 16,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         EN;
  logic                         i_VALID;
  logic [CHANNELS*BITNESS-1:0]  i_DATA;
  logic                         o_VALID;
  logic [CHANNELS*BITNESS-1:0]  o_DATA;
  logic [CNT_W-1:0]             o_COUNT;
  logic                         o_FULL;
  logic                         o_EMPTY;

  modport master (
    output EN, i_VALID, i_DATA,
    input  o_VALID, o_DATA, o_COUNT, o_FULL, o_EMPTY
  );

  modport slave (
    input  EN, i_VALID, i_DATA,
    output o_VALID, o_DATA, o_COUNT, o_FULL, o_EMPTY
  );
endinterface

// File: rtl/param_delay_line.sv
// Multi-channel stallable delay line with per-stage valid bits and occupancy count.
// Optional synchronous clear port i_CLR when PARAM_DELAY_LINE_CLR_EN is defined.
module param_delay_line #(
  parameter int BITNESS  = 16,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST_N,
`ifdef PARAM_DELAY_LINE_CLR_EN
  input  logic                i_CLR,
`endif
  param_delay_line_if.slave   bus
);
  localparam int W = CHANNELS * BITNESS;

  logic [W-1:0]     data_q  [DEPTH];
  logic             valid_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             clr;

`ifdef PARAM_DELAY_LINE_CLR_EN
  assign clr = i_CLR;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
      end
      count_q <= '0;
    end else if (clr) begin
      // clear wins over EN; the word presented this cycle is dropped
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
      end
      count_q <= '0;
    end else if (bus.EN) begin
      data_q[0]  <= bus.i_DATA;
      valid_q[0] <= bus.i_VALID;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      count_q <= count_q + CNT_W'(bus.i_VALID) - CNT_W'(valid_q[DEPTH-1]);
    end
  end

  assign bus.o_DATA  = data_q[DEPTH-1];
  assign bus.o_VALID = valid_q[DEPTH-1];
  assign bus.o_COUNT = count_q;
  assign bus.o_FULL  = (count_q == CNT_W'(DEPTH));
  assign bus.o_EMPTY = (count_q == '0);

endmodule
